// File: rtl/tube_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// tube_display_ctrl_if
//   CPU register bus into the tube display controller.
//
//   addr   : byte address within the block, addr[3:2] picks the register
//   we     : one-cycle write strobe
//   wdata  : write data
//   rdata  : read data, combinational from addr
//
//   master : CPU side (drives addr/we/wdata, receives rdata)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface tube_display_ctrl_if;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/tube_display_ctrl.sv
// -----------------------------------------------------------------------------
// tube_display_ctrl
//   Memory-mapped controller for two 4-digit digital tubes (8 hex digits).
//   Holds the CPU display value, per-tube enables and blink setup, and hands
//   the tubes to a debug source on request. Every ownership switch is held
//   for at least HOLD_CYCLES cycles so the display cannot flicker.
//   The low tube takes tube_data[15:0], the high tube tube_data[31:16].
//
//   Registers (addr[3:2]):
//     0 DATA      rw  display value
//     1 CTRL      rw  bit0 en0, bit1 en1, bit2 blink
//     2 BLINK_DIV rw  blink half-period in cycles (0 freezes the blink)
//     3 STATUS    ro  bit0 src (1 = debug), bit1 blink phase, bit2 hold busy
//
//   Ports:
//     clk       system clock
//     reset     synchronous, active-high reset
//     bus       CPU register bus (slave modport)
//     dbg_req   debug source requests the display (level)
//     dbg_data  debug value to show
//     tube_data registered value to the tubes
//     tube_en   registered tube enables, bit0 low tube, bit1 high tube
// -----------------------------------------------------------------------------
module tube_display_ctrl #(
  parameter logic [31:0] HOLD_CYCLES   = 32'd1_000_000,
  parameter logic [31:0] BLINK_DEFAULT = 32'd12_500_000
) (
  input  logic                clk,
  input  logic                reset,
  tube_display_ctrl_if.slave  bus,
  input  logic                dbg_req,
  input  logic [31:0]         dbg_data,
  output logic [31:0]         tube_data,
  output logic [1:0]          tube_en
);

  typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} src_e;

  logic [31:0] data_q;
  logic [2:0]  ctrl_q;
  logic [31:0] div_q;
  logic [31:0] bcnt_q;
  logic        phase_q;
  src_e        src_q;
  logic [31:0] hold_q;

  logic wr_data, wr_ctrl, wr_div, blink_clear;
  logic unused_addr_bits;

  // Byte lanes within a word are not decoded.
  assign unused_addr_bits = ^bus.addr[1:0];

  assign wr_data = bus.we && (bus.addr[3:2] == 2'd0);
  assign wr_ctrl = bus.we && (bus.addr[3:2] == 2'd1);
  assign wr_div  = bus.we && (bus.addr[3:2] == 2'd2);

  // A CTRL write that clears blink must beat a phase toggle landing on the
  // same edge, so the incoming write is looked at, not just the stored bit.
  assign blink_clear = !ctrl_q[2] || (wr_ctrl && !bus.wdata[2]);

  // Register file and blink engine.
  // NOTE: every flop, including the config registers, is reset; sequential
  // state is only ever assigned with <= so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      ctrl_q  <= 3'b011;
      div_q   <= BLINK_DEFAULT;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      if (wr_data) data_q <= bus.wdata;
      if (wr_ctrl) ctrl_q <= bus.wdata[2:0];
      if (wr_div)  div_q  <= bus.wdata;

      if (blink_clear) begin
        bcnt_q  <= '0;
        phase_q <= 1'b1;
      end else if (wr_div) begin
        bcnt_q  <= '0;                      // restart the half-period, keep phase
      end else if (div_q != '0) begin
        if (bcnt_q + 32'd1 == div_q) begin
          bcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          bcnt_q  <= bcnt_q + 32'd1;
        end
      end
    end
  end

  // Source arbitration with hold-off, plus the registered tube outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= S_CPU;
      hold_q    <= '0;
      tube_data <= '0;
      tube_en   <= 2'b11;
    end else begin
      tube_data <= (src_q == S_DBG) ? dbg_data : data_q;
      tube_en   <= (src_q == S_DBG) ? 2'b11 : (ctrl_q[1:0] & {2{phase_q}});

      if (hold_q != '0) begin
        hold_q <= hold_q - 32'd1;           // still locked, no switch allowed
      end else begin
        case (src_q)
          S_CPU: if (dbg_req) begin
            src_q  <= S_DBG;
            hold_q <= HOLD_CYCLES - 32'd1;
          end
          S_DBG: if (!dbg_req) begin
            src_q  <= S_CPU;
            hold_q <= HOLD_CYCLES - 32'd1;
          end
          default: src_q <= S_CPU;
        endcase
      end
    end
  end

  // Read mux.
  // NOTE: rdata gets a default before the case so no latch can be inferred.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr[3:2])
      2'd0: bus.rdata = data_q;
      2'd1: bus.rdata = {29'd0, ctrl_q};
      2'd2: bus.rdata = div_q;
      2'd3: bus.rdata = {29'd0, (hold_q != '0), phase_q, (src_q == S_DBG)};
      default: bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tube_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tube_display_ctrl
//   Directed bench for tube_display_ctrl with a cycle-level reference model.
//   The model tracks ownership by edge timestamps and the blink phase by
//   elapsed counted cycles; a negedge process compares tube_data, tube_en and
//   rdata against it every cycle, and the stimulus adds literal checks.
// -----------------------------------------------------------------------------
module tb_tube_display_ctrl;

  localparam logic [31:0] HOLD = 32'd4;
  localparam logic [31:0] BDEF = 32'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_req;
  logic [31:0] dbg_data;
  logic [31:0] tube_data;
  logic [1:0]  tube_en;

  tube_display_ctrl_if bus ();

  tube_display_ctrl #(
    .HOLD_CYCLES   (HOLD),
    .BLINK_DEFAULT (BDEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_req   (dbg_req),
    .dbg_data  (dbg_data),
    .tube_data (tube_data),
    .tube_en   (tube_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          model_ok = 1'b0;
  longint      n = 0;          // edge index
  longint      last_sw;        // edge of the last ownership switch
  bit          m_src;          // 1 = debug owns the tubes
  logic [31:0] m_data;
  logic [2:0]  m_ctrl;
  logic [31:0] m_div;
  bit          m_base;         // phase at the start of the current blink run
  longint      m_age;          // counted cycles since the run started
  logic [31:0] e_data;
  logic [1:0]  e_en;
  bit          p_now;

  function automatic bit m_phase();
    if (m_div == 32'd0) return m_base;
    return m_base ^ (((m_age / longint'(m_div)) % 2) != 0);
  endfunction

  function automatic bit m_busy();
    return n < last_sw + longint'(HOLD) - 1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_data;
      2'd1:    return {29'd0, m_ctrl};
      2'd2:    return m_div;
      default: return {29'd0, m_busy(), m_phase(), m_src};
    endcase
  endfunction

  always @(posedge clk) begin
    n++;
    if (reset) begin
      model_ok = 1'b1;
      last_sw  = n - longint'(HOLD);
      m_src    = 1'b0;
      m_data   = '0;
      m_ctrl   = 3'b011;
      m_div    = BDEF;
      m_base   = 1'b1;
      m_age    = 0;
      e_data   = '0;
      e_en     = 2'b11;
    end else if (model_ok) begin
      p_now  = m_phase();
      e_data = m_src ? dbg_data : m_data;
      e_en   = m_src ? 2'b11 : (m_ctrl[1:0] & {2{p_now}});

      if (n >= last_sw + longint'(HOLD) && (dbg_req != m_src)) begin
        m_src   = dbg_req;
        last_sw = n;
      end

      if (!m_ctrl[2] || (bus.we && bus.addr[3:2] == 2'd1 && !bus.wdata[2])) begin
        m_base = 1'b1;
        m_age  = 0;
      end else if (bus.we && bus.addr[3:2] == 2'd2) begin
        m_base = p_now;
        m_age  = 0;
      end else if (m_div != 32'd0) begin
        m_age++;
      end

      if (bus.we) begin
        case (bus.addr[3:2])
          2'd0:    m_data = bus.wdata;
          2'd1:    m_ctrl = bus.wdata[2:0];
          2'd2:    m_div  = bus.wdata;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc tube_data", tube_data, e_data);
      check("cyc tube_en", {30'd0, tube_en}, {30'd0, e_en});
      check("cyc rdata", bus.rdata, exp_rd(bus.addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input string name, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.rdata, exp);
  endtask

  initial begin
    reset     = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    dbg_req   = 1'b0;
    dbg_data  = '0;
    tick(2);
    check("rst tube_data", tube_data, 32'h0);
    check("rst tube_en", {30'd0, tube_en}, 32'h3);
    reset = 1'b0;
    rd(4'h8, "rst blink_div", BDEF);
    rd(4'h4, "rst ctrl", 32'h3);
    rd(4'hC, "rst status", 32'h2);

    // DATA write visible one cycle later
    wr(4'h0, 32'h1234_ABCD);
    tick();
    check("data out", tube_data, 32'h1234_ABCD);
    check("data en", {30'd0, tube_en}, 32'h3);
    rd(4'h0, "data rd", 32'h1234_ABCD);

    // CTRL enables and masking
    wr(4'h4, 32'h2);
    tick();
    check("ctrl en1 only", {30'd0, tube_en}, 32'h2);
    rd(4'h4, "ctrl rd", 32'h2);
    wr(4'h4, 32'hFFFF_FFFF);
    rd(4'h4, "ctrl mask", 32'h7);

    // blink with half-period 3
    wr(4'h5, 32'h3);                 // addr[1:0] ignored: CTRL, blink off
    wr(4'h8, 32'h3);
    wr(4'h4, 32'h7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("blink pattern", {30'd0, tube_en}, ((i / 3) % 2 != 0) ? 32'h0 : 32'h3);
    end
    wr(4'h4, 32'h3);                 // clear blink while dark
    check("blink clear edge", {30'd0, tube_en}, 32'h0);
    tick();
    check("blink clear next", {30'd0, tube_en}, 32'h3);

    // clear blink on the very edge where phase would toggle
    wr(4'h4, 32'h7);
    tick(2);
    wr(4'h4, 32'h3);
    tick();
    check("clear beats toggle", {30'd0, tube_en}, 32'h3);

    // BLINK_DIV = 0 freezes the phase
    wr(4'h8, 32'h0);
    wr(4'h4, 32'h7);
    tick(5);
    check("div0 frozen", {30'd0, tube_en}, 32'h3);
    wr(4'h4, 32'h3);
    wr(4'h8, 32'h3);

    // STATUS is read-only
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, "status ro", 32'h2);

    // one-cycle debug pulse forces the full hold
    wr(4'h0, 32'h1111_1111);
    dbg_data = 32'hDEAD_BEEF;
    dbg_req  = 1'b1;
    tick();
    dbg_req  = 1'b0;
    check("pulse edge", tube_data, 32'h1111_1111);
    rd(4'hC, "status hold", 32'h7);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("pulse hold", tube_data, (i <= 4) ? 32'hDEAD_BEEF : 32'h1111_1111);
    end
    tick(4);

    // held request with a CPU write during debug ownership
    dbg_req = 1'b1;
    tick(3);
    wr(4'h0, 32'h55);
    tick(3);
    check("dbg keeps", tube_data, 32'hDEAD_BEEF);
    rd(4'h0, "data stored", 32'h55);
    dbg_req = 1'b0;
    tick();
    check("release edge", tube_data, 32'hDEAD_BEEF);
    tick();
    check("release shows", tube_data, 32'h55);

    // reset in debug ownership with hold = 2 and request still high
    tick(4);
    dbg_req = 1'b1;
    tick(2);
    reset = 1'b1;
    tick();
    check("mid rst data", tube_data, 32'h0);
    check("mid rst en", {30'd0, tube_en}, 32'h3);
    rd(4'hC, "mid rst status", 32'h2);
    reset = 1'b0;
    tick();
    rd(4'hC, "post rst status", 32'h7);
    check("post rst data", tube_data, 32'h0);
    tick();
    check("post rst dbg", tube_data, 32'hDEAD_BEEF);
    dbg_req = 1'b0;
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_display_ctrl.md
Name: tube_display_ctrl

Overview:
- Memory-mapped controller for the two 4-digit digital tubes (8 hex digits total) on the board.
- Holds the 32-bit display value, per-tube enables and blink configuration written by the CPU bus.
- Arbitrates tube ownership between the CPU and a debug source (e.g. PC snoop), with a minimum hold time so the display does not flicker.
- Drives `data`/`en` of two `digital_tube` instances: low tube takes `tube_data[15:0]`, high tube takes `tube_data[31:16]`.

Parameters:
- HOLD_CYCLES, 32'd1_000_000: minimum cycles the source stays selected after any switch (≥1).
- BLINK_DEFAULT, 32'd12_500_000: reset value of BLINK_DIV, the blink half-period in cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  4  byte address within block; `addr[3:2]` selects register, `addr[1:0]` ignored
- we  input  1  write strobe, one cycle per write
- wdata  input  32  write data
- rdata  output  32  read data, combinational from `addr`
- dbg_req  input  1  debug source requests the display (level)
- dbg_data  input  32  debug value to show
- tube_data  output  32  value to the tubes
- tube_en  output  2  enables: bit0 low tube, bit1 high tube

Behaviour:
- Registers, indexed by `addr[3:2]`:
  - 0 DATA: rw, 32 bits, reset 0.
  - 1 CTRL: rw. bit0 en0, bit1 en1, bit2 blink. Reset 3'b011. Bits 31:3 read 0, write ignored.
  - 2 BLINK_DIV: rw, 32 bits, reset BLINK_DEFAULT.
  - 3 STATUS: ro. bit0 src (1 = DBG), bit1 blink phase, bit2 hold_busy (hold≠0). Other bits 0. Writes ignored.
- Writes: a write with `we`=1 updates the register at the clk edge. Outputs reflect it the next cycle. `rdata` in the write cycle shows the old value.
- Source FSM, states S_CPU (reset) and S_DBG. Hold counter `hold` resets to 0.
  - S_CPU: `dbg_req`=1 and `hold`==0 → S_DBG, load `hold`=HOLD_CYCLES-1.
  - S_DBG: `dbg_req`=0 and `hold`==0 → S_CPU, load `hold`=HOLD_CYCLES-1.
  - In any state with `hold`≠0: decrement `hold`; no transition is possible that cycle.
  - A `dbg_req` pulse shorter than the hold still forces the full hold in S_DBG. Return to S_CPU happens on the first cycle with `hold`==0 and `dbg_req`=0.
- Blink engine: counter `bcnt` (32b) and `phase` (reset 1 = visible).
  - CTRL.blink=0: `bcnt`=0, `phase`=1 every cycle.
  - CTRL.blink=1 and BLINK_DIV≠0: `bcnt` increments. When `bcnt`+1==BLINK_DIV, `bcnt`→0 and `phase` toggles.
  - BLINK_DIV==0: `bcnt` and `phase` frozen.
  - Any write to BLINK_DIV clears `bcnt` (phase unchanged).
- Outputs, registered, with reset values `tube_data`=0 and `tube_en`=2'b11:
  - S_DBG: `tube_data`=`dbg_data`, `tube_en`=2'b11. Blink and CTRL enables are ignored.
  - S_CPU: `tube_data`=DATA, `tube_en`={en1,en0} & {2{phase}}.
  - Latency: one cycle from register/state change to output.
- CPU writes during S_DBG are accepted and stored. They become visible on return to S_CPU.
- Simultaneous write to CTRL clearing blink and phase-toggle cycle: blink clear wins, `phase`=1.
- Reset mid-operation: all state returns to reset values next edge, including `hold`=0, so an active `dbg_req` switches to S_DBG one cycle after reset deasserts.

Test Plan:
- Reset, then write DATA=0x1234_ABCD → next cycle `tube_data`=0x1234ABCD, `tube_en`=2'b11; read addr 0 returns 0x1234ABCD.
- Write CTRL=0x2 → `tube_en`=2'b10; read CTRL returns 0x2; write CTRL=0xFFFF_FFFF → read returns 0x7.
- HOLD_CYCLES=4, BLINK_DIV=3, CTRL=0x7:
  - `tube_en` alternates 2'b11 for 3 cycles, 2'b00 for 3 cycles.
  - Clearing blink mid-off-phase → 2'b11 next cycle.
- HOLD_CYCLES=4, DATA=0x11111111, `dbg_data`=0xDEADBEEF, 1-cycle `dbg_req` pulse:
  - `tube_data`=0xDEADBEEF for exactly 4 cycles, then 0x11111111.
  - STATUS bit2=1 during the hold.
- `dbg_req` held high with a CPU write DATA=0x55 during S_DBG → `tube_data` stays 0xDEADBEEF; after release and hold expiry it shows 0x00000055.
- Assert `reset` while in S_DBG with `hold`=2 and `dbg_req`=1 → outputs return to reset values; state re-enters S_DBG on the first post-reset cycle.
